ir_packet_gen: RTL and testbench



---
 rtl/ir_pkg.sv | 57 +++++
 rtl/ir_carrier_gen.sv | 41 ++++
 rtl/ir_packet_gen.sv | 146 ++++++++++++++
 tb/tb_ir_packet_gen.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared types and per-colour timing tables for the IR remote-control-car packet generator.
// Colour index order everywhere: blue, yellow, green, red.
package ir_pkg;

  typedef enum logic [1:0] {
    CarBlue   = 2'd0,
    CarYellow = 2'd1,
    CarGreen  = 2'd2,
    CarRed    = 2'd3
  } car_e;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StGap,
    StCarSel,
    StRight,
    StLeft,
    StBack,
    StFwd
  } ir_state_e;

  localparam int unsigned NumCars = 4;

  // Bit positions within the CONTROL command
  localparam int unsigned CtrlRight = 0;
  localparam int unsigned CtrlLeft  = 1;
  localparam int unsigned CtrlBack  = 2;
  localparam int unsigned CtrlFwd   = 3;

  localparam int unsigned CARRIER_HZ [NumCars] = '{36_000, 40_000, 37_500, 40_000};

  // Burst and gap lengths, in whole carrier periods
  localparam logic [7:0] START_N    [NumCars] = '{8'd191, 8'd88, 8'd88, 8'd192};
  localparam logic [7:0] GAP_N      [NumCars] = '{8'd25,  8'd40, 8'd40, 8'd24};
  localparam logic [7:0] CARSEL_N   [NumCars] = '{8'd47,  8'd22, 8'd44, 8'd24};
  localparam logic [7:0] ASSERT_N   [NumCars] = '{8'd47,  8'd28, 8'd28, 8'd48};
  localparam logic [7:0] DEASSERT_N [NumCars] = '{8'd22,  8'd10, 8'd10, 8'd24};

  // Carrier half-period in system clocks, rounded down
  function automatic logic [10:0] half_period_f(int unsigned clk_hz, car_e car);
    return 11'(clk_hz / (2 * CARRIER_HZ[car]));
  endfunction

  // Burst that follows the gap after the given burst; StIdle ends the packet
  function automatic ir_state_e next_burst(ir_state_e st);
    case (st)
      StStart:  return StCarSel;
      StCarSel: return StRight;
      StRight:  return StLeft;
      StLeft:   return StBack;
      StBack:   return StFwd;
      default:  return StIdle;
    endcase
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Square-wave IR carrier: high for half_period clocks, then low for half_period clocks.
// The counter spans one half-period so it stays within 11 bits for every colour.
module ir_carrier_gen (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        restart,
  input  logic [10:0] half_period,
  output logic        carrier,
  output logic        cyc_done
);

  logic [10:0] cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic        half_end;

  always_comb begin
    // >= keeps the counter wrapping if half_period shrinks mid-count
    half_end = (cnt_q >= (half_period - 11'd1));
    cnt_d    = half_end ? 11'd0 : cnt_q + 11'd1;
    phase_d  = half_end ? ~phase_q : phase_q;
    if (restart) begin
      cnt_d   = 11'd0;
      phase_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q   <= 11'd0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // carrier is the level for the coming cycle, so the parent can register it with its state
  assign carrier  = phase_d;
  assign cyc_done = half_end & ~phase_q;

endmodule

// File: rtl/ir_packet_gen.sv
// Periodic IR packet generator: latches colour and command on each accepted period tick and
// plays Start, CarSelect and four direction bursts, each followed by a gap, on IR_LED.
module ir_packet_gen
  import ir_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned PKT_PERIOD_CYC = 10_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic [1:0] CAR_SEL,
  input  logic [3:0] CONTROL,
  output logic       IR_LED,
  output logic       BUSY,
  output logic       PKT_DONE
);

  localparam int unsigned TimerW = (PKT_PERIOD_CYC > 1) ? $clog2(PKT_PERIOD_CYC) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(PKT_PERIOD_CYC - 1);

  // Folded to constants per colour so no divider is built
  localparam logic [10:0] HalfPeriod [NumCars] = '{
    half_period_f(CLK_HZ, CarBlue),
    half_period_f(CLK_HZ, CarYellow),
    half_period_f(CLK_HZ, CarGreen),
    half_period_f(CLK_HZ, CarRed)
  };

  logic [TimerW-1:0] timer_q;
  logic              tick;
  logic              pkt_start;

  ir_state_e   st_q, nxt_q;
  logic [7:0]  seg_q;
  logic [7:0]  dur;
  logic        seg_last;
  car_e        car_q;
  logic [3:0]  ctrl_q;
  logic        ir_led_q, busy_q;

  logic [10:0] half_period;
  logic        carrier, cyc_done;

  // Period timer runs only while enabled; ticks landing mid-packet are simply ignored
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      timer_q <= '0;
    end else if (!ENABLE || (timer_q == TimerLast)) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 1'b1;
    end
  end

  assign tick      = ENABLE && (timer_q == TimerLast);
  assign pkt_start = tick && (st_q == StIdle);

  assign half_period = HalfPeriod[car_q];

  ir_carrier_gen u_carrier (
    .CLK         (CLK),
    .RESET       (RESET),
    .restart     (pkt_start),
    .half_period (half_period),
    .carrier     (carrier),
    .cyc_done    (cyc_done)
  );

  always_comb begin
    dur = GAP_N[car_q];
    unique case (st_q)
      StStart:  dur = START_N[car_q];
      StCarSel: dur = CARSEL_N[car_q];
      StRight:  dur = ctrl_q[CtrlRight] ? ASSERT_N[car_q] : DEASSERT_N[car_q];
      StLeft:   dur = ctrl_q[CtrlLeft]  ? ASSERT_N[car_q] : DEASSERT_N[car_q];
      StBack:   dur = ctrl_q[CtrlBack]  ? ASSERT_N[car_q] : DEASSERT_N[car_q];
      StFwd:    dur = ctrl_q[CtrlFwd]   ? ASSERT_N[car_q] : DEASSERT_N[car_q];
      default:  dur = GAP_N[car_q];
    endcase
  end

  assign seg_last = cyc_done && (seg_q == (dur - 8'd1));

  // Segment boundaries always fall on carrier period ends, so the carrier is only restarted
  // at packet start and free-runs across bursts and gaps.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      st_q     <= StIdle;
      nxt_q    <= StIdle;
      seg_q    <= 8'd0;
      car_q    <= CarBlue;
      ctrl_q   <= 4'd0;
      ir_led_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      ir_led_q <= 1'b0;
      unique case (st_q)
        StIdle: begin
          seg_q <= 8'd0;
          if (tick) begin
            car_q    <= car_e'(CAR_SEL);
            ctrl_q   <= CONTROL;
            st_q     <= StStart;
            busy_q   <= 1'b1;
            ir_led_q <= carrier;
          end
        end
        StGap: begin
          if (seg_last) begin
            seg_q <= 8'd0;
            st_q  <= nxt_q;
            if (nxt_q == StIdle) begin
              busy_q <= 1'b0;
            end else begin
              ir_led_q <= carrier;
            end
          end else if (cyc_done) begin
            seg_q <= seg_q + 8'd1;
          end
        end
        StStart, StCarSel, StRight, StLeft, StBack, StFwd: begin
          if (seg_last) begin
            seg_q <= 8'd0;
            st_q  <= StGap;
            nxt_q <= next_burst(st_q);
          end else begin
            if (cyc_done) begin
              seg_q <= seg_q + 8'd1;
            end
            ir_led_q <= carrier;
          end
        end
        default: begin
          st_q   <= StIdle;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign IR_LED   = ir_led_q;
  assign BUSY     = busy_q;
  assign PKT_DONE = (st_q == StGap) && (nxt_q == StIdle) && seg_last;

endmodule

// File: tb/tb_ir_packet_gen.sv
// Directed bench for ir_packet_gen: a monitor decodes each packet off IR_LED/BUSY/PKT_DONE and
// the stimulus block compares it against expectations queued when the command was driven.
module tb_ir_packet_gen;

  localparam int unsigned ClkHz  = 300_000;
  localparam int unsigned Period = 2000;
  localparam int unsigned Limit  = 3 * Period + 100;
  localparam int          GapThresh = 50;

  typedef struct {
    int r0, r1, r2, r3, r4, r5;
    int nbursts;
    int gap_first;
    int gaps_bad;
    int final_gap;
    int hi_min, hi_max;
    int len;
    int first_led;
    int done_cnt;
    int done_last;
    int start;
  } pkt_t;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [1:0] car_sel;
  logic [3:0] control;
  logic       ir_led, busy, pkt_done;

  pkt_t obs_q [$];
  pkt_t exp_q [$];

  int checks = 0;
  int errors = 0;
  int last_start = 0;
  int last_len = 0;
  int lat;

  // monitor state
  int   m_cyc, m_burst, m_any_rise, m_run_lo, m_run_hi, m_len;
  int   m_gap_first, m_gaps_bad, m_hi_min, m_hi_max, m_first_led;
  int   m_done_cnt, m_done_last, m_start, m_stray;
  int   m_rises [8];
  bit   m_in, m_prev_led;
  pkt_t m_pkt;

  ir_packet_gen #(
    .CLK_HZ         (ClkHz),
    .PKT_PERIOD_CYC (Period)
  ) dut (
    .CLK      (clk),
    .RESET    (rst_n),
    .ENABLE   (enable),
    .CAR_SEL  (car_sel),
    .CONTROL  (control),
    .IR_LED   (ir_led),
    .BUSY     (busy),
    .PKT_DONE (pkt_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pkt_t model(int car, logic [3:0] ctl);
    pkt_t e;
    int hz, st, gp, cs, as, de, h;
    case (car)
      0:       begin hz = 36000; st = 191; gp = 25; cs = 47; as = 47; de = 22; end
      1:       begin hz = 40000; st = 88;  gp = 40; cs = 22; as = 28; de = 10; end
      2:       begin hz = 37500; st = 88;  gp = 40; cs = 44; as = 28; de = 10; end
      default: begin hz = 40000; st = 192; gp = 24; cs = 24; as = 48; de = 24; end
    endcase
    h = int'(ClkHz) / (2 * hz);
    e.r0 = st;
    e.r1 = cs;
    e.r2 = ctl[0] ? as : de;
    e.r3 = ctl[1] ? as : de;
    e.r4 = ctl[2] ? as : de;
    e.r5 = ctl[3] ? as : de;
    e.nbursts   = 6;
    e.gap_first = h + 2 * h * gp;
    e.gaps_bad  = 0;
    e.final_gap = h + 2 * h * gp;
    e.hi_min    = h;
    e.hi_max    = h;
    e.len       = 2 * h * (e.r0 + e.r1 + e.r2 + e.r3 + e.r4 + e.r5 + 6 * gp);
    e.first_led = 1;
    e.done_cnt  = 1;
    e.done_last = 1;
    e.start     = 0;
    return e;
  endfunction

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Waits for the next BUSY rise; lat counts negedges from the call to the first busy sample
  task automatic wait_start(string tag, output int n_lat);
    int n = 0;
    while (busy && n < int'(Limit)) begin
      @(negedge clk);
      n++;
    end
    n_lat = 0;
    do begin
      @(negedge clk);
      n_lat++;
    end while (!busy && n_lat < int'(Limit));
    if (!busy) chk({tag, ".start_timeout"}, int'(busy), 1);
  endtask

  task automatic drain(string tag, bit space);
    int   n = 0;
    pkt_t o, e;
    while (obs_q.size() == 0 && n < 12000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".arrived"}, int'(obs_q.size() > 0), 1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      chk({tag, ".start_n"},   o.r0, e.r0);
      chk({tag, ".carsel_n"},  o.r1, e.r1);
      chk({tag, ".right_n"},   o.r2, e.r2);
      chk({tag, ".left_n"},    o.r3, e.r3);
      chk({tag, ".back_n"},    o.r4, e.r4);
      chk({tag, ".fwd_n"},     o.r5, e.r5);
      chk({tag, ".bursts"},    o.nbursts, e.nbursts);
      chk({tag, ".gap_low"},   o.gap_first, e.gap_first);
      chk({tag, ".gaps_bad"},  o.gaps_bad, e.gaps_bad);
      chk({tag, ".last_gap"},  o.final_gap, e.final_gap);
      chk({tag, ".hi_min"},    o.hi_min, e.hi_min);
      chk({tag, ".hi_max"},    o.hi_max, e.hi_max);
      chk({tag, ".busy_len"},  o.len, e.len);
      chk({tag, ".first_led"}, o.first_led, e.first_led);
      chk({tag, ".done_cnt"},  o.done_cnt, e.done_cnt);
      chk({tag, ".done_last"}, o.done_last, e.done_last);
      if (space) begin
        chk({tag, ".spacing"}, o.start - last_start,
            int'(Period) * ((last_len + int'(Period)) / int'(Period)));
      end
      last_start = o.start;
      last_len   = e.len;
    end
  endtask

  // Packet decoder
  initial begin : monitor
    m_cyc = 0;
    m_in = 1'b0;
    m_stray = 0;
    forever begin
      @(negedge clk);
      m_cyc++;
      if (!rst_n) begin
        m_in = 1'b0;
      end else begin
        if (pkt_done && !busy) m_stray++;
        if (m_in && !busy) begin
          m_pkt.r0 = m_rises[0];
          m_pkt.r1 = m_rises[1];
          m_pkt.r2 = m_rises[2];
          m_pkt.r3 = m_rises[3];
          m_pkt.r4 = m_rises[4];
          m_pkt.r5 = m_rises[5];
          m_pkt.nbursts   = m_any_rise ? m_burst + 1 : 0;
          m_pkt.gap_first = m_gap_first;
          m_pkt.gaps_bad  = m_gaps_bad;
          m_pkt.final_gap = m_run_lo;
          m_pkt.hi_min    = m_hi_min;
          m_pkt.hi_max    = m_hi_max;
          m_pkt.len       = m_len;
          m_pkt.first_led = m_first_led;
          m_pkt.done_cnt  = m_done_cnt;
          m_pkt.done_last = m_done_last;
          m_pkt.start     = m_start;
          obs_q.push_back(m_pkt);
          m_in = 1'b0;
        end else if (!m_in && busy) begin
          m_in = 1'b1;
          for (int i = 0; i < 8; i++) m_rises[i] = 0;
          m_burst = 0;
          m_any_rise = 0;
          m_run_lo = 0;
          m_run_hi = 0;
          m_len = 0;
          m_gap_first = 0;
          m_gaps_bad = 0;
          m_hi_min = 1 << 30;
          m_hi_max = 0;
          m_first_led = int'(ir_led);
          m_done_cnt = 0;
          m_done_last = 0;
          m_start = m_cyc;
          m_prev_led = 1'b0;
        end
        if (m_in) begin
          m_len++;
          if (pkt_done) m_done_cnt++;
          m_done_last = int'(pkt_done);
          if (ir_led) begin
            if (!m_prev_led) begin
              if (m_any_rise != 0 && m_run_lo > GapThresh) begin
                if (m_burst == 0) m_gap_first = m_run_lo;
                else if (m_run_lo != m_gap_first) m_gaps_bad++;
                m_burst++;
              end
              if (m_burst < 8) m_rises[m_burst]++;
              m_any_rise = 1;
              m_run_hi = 0;
            end
            m_run_hi++;
            m_run_lo = 0;
          end else begin
            if (m_prev_led) begin
              if (m_run_hi < m_hi_min) m_hi_min = m_run_hi;
              if (m_run_hi > m_hi_max) m_hi_max = m_run_hi;
            end
            m_run_lo++;
          end
          m_prev_led = ir_led;
        end
      end
    end
  end

  initial begin : stimulus
    int act;
    int n;
    rst_n   = 1'b0;
    enable  = 1'b0;
    car_sel = 2'd0;
    control = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset.ir_led", int'(ir_led), 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.pkt_done", int'(pkt_done), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Blue, no command; the first packet starts one full period after enable rises
    car_sel = 2'd0;
    control = 4'b0000;
    exp_q.push_back(model(0, 4'b0000));
    enable = 1'b1;
    wait_start("p1", lat);
    chk("p1.enable_latency", lat, int'(Period));
    // Already latched: these belong to the next packet
    car_sel = 2'd3;
    control = 4'b1001;
    exp_q.push_back(model(3, 4'b1001));

    wait_start("p2", lat);
    car_sel = 2'd1;
    control = 4'b0100;
    exp_q.push_back(model(1, 4'b0100));

    wait_start("p3", lat);
    repeat (100) @(negedge clk);
    control = 4'b1111;
    exp_q.push_back(model(1, 4'b1111));

    wait_start("p4", lat);
    car_sel = 2'd2;
    control = 4'b0010;
    exp_q.push_back(model(2, 4'b0010));

    // Drop enable inside the green LEFT burst (offsets 2096..2319 from packet start)
    wait_start("p5", lat);
    repeat (2196) @(negedge clk);
    chk("p5.busy_mid_left", int'(busy), 1);
    enable = 1'b0;
    n = 0;
    while (busy && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("p5.finished", int'(busy), 0);
    act = 0;
    repeat (3 * Period) begin
      @(negedge clk);
      if (busy || ir_led) act++;
    end
    chk("quiet_after_disable", act, 0);

    drain("p1", 1'b0);
    drain("p2", 1'b1);
    drain("p3", 1'b1);
    drain("p4", 1'b1);
    drain("p5", 1'b1);

    // Reset during a blue START burst, then a clean full packet afterwards
    car_sel = 2'd0;
    control = 4'b0000;
    enable = 1'b1;
    wait_start("rst_pre", lat);
    chk("rst_pre.enable_latency", lat, int'(Period));
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst.ir_led", int'(ir_led), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.pkt_done", int'(pkt_done), 0);
    repeat (3) @(negedge clk);
    chk("rst.busy_held", int'(busy), 0);
    rst_n = 1'b1;
    exp_q.push_back(model(0, 4'b0000));
    wait_start("p6", lat);
    chk("p6.reset_latency", lat, int'(Period));
    drain("p6", 1'b0);
    enable = 1'b0;
    repeat (10) @(negedge clk);

    chk("stray_pkt_done", m_stray, 0);
    chk("leftover_packets", obs_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
